// File: rtl/trig_id_receiver_pkg.sv
// -----------------------------------------------------------------------------
// trig_id_receiver_pkg
//   Shared types and constants for the trigger-ID receiver.
//   - fsm_state_t : capture state machine encoding (IDLE / CAPTURE)
//   - DROP_CNT_W  : width of the saturating dropped-ID counter
//   - clog2()     : ceiling log2, usable in parameter and port-width expressions
// -----------------------------------------------------------------------------
package trig_id_receiver_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } fsm_state_t;

  localparam int DROP_CNT_W = 8;

  // Smallest r with 2**r >= value; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/trig_id_receiver_id_fifo.sv
// -----------------------------------------------------------------------------
// id_fifo
//   Circular buffer for completed trigger IDs. Pointers carry one extra bit
//   above the address so that full and empty are distinguishable; both wrap in
//   natural binary. The head word is read combinationally so that a word is
//   visible in the same cycle the buffer becomes non-empty, and it reads as 0
//   while the buffer is empty.
//
// Ports
//   clk      in   clock
//   reset    in   synchronous active-high reset, empties the buffer
//   push_i   in   write wdata_i (dropped when full unless a pop happens too)
//   wdata_i  in   WIDTH  word to write
//   pop_i    in   discard head word (ignored when empty)
//   full_o   out  DEPTH words stored
//   empty_o  out  no words stored
//   level_o  out  clog2(DEPTH)+1  number of stored words
//   rdata_o  out  WIDTH  head word, 0 when empty
// -----------------------------------------------------------------------------
module id_fifo
  import trig_id_receiver_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [clog2(DEPTH):0]  level_o,
  output logic [WIDTH-1:0]       rdata_o
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [AW:0]      wr_ptr_d;
  logic [AW:0]      rd_ptr_d;
  logic             pop_en;
  logic             push_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

  // A pop frees a slot in the same cycle, so a push into a full buffer
  // succeeds when it coincides with a pop.
  assign pop_en  = pop_i && !empty_o;
  assign push_en = push_i && (!full_o || pop_en);

  assign wr_ptr_d = push_en ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop_en  ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; its content is only visible through rd_ptr_q.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/trig_id_receiver.sv
// -----------------------------------------------------------------------------
// trig_id_receiver
//   Captures serial trigger IDs framed by a rising edge of trig_sync and
//   clocked in by bit_strobe, buffers completed IDs for readout and raises
//   interrupt while any ID is waiting. Captures that stall (no strobe within
//   TIMEOUT_CYCLES) or are cut short by a new trigger are aborted and counted;
//   completed IDs that find the buffer full are dropped and counted.
//
// Ports
//   clk           in   sampling clock
//   reset         in   synchronous active-high reset
//   trig_sync     in   trigger level, synchronised; rising edge starts capture
//   id_bit_sync   in   serial ID data, synchronised
//   bit_strobe    in   one-cycle pulse qualifying id_bit_sync
//   rd_pop        in   consume the head ID (ignored when rd_valid=0)
//   err_clear     in   clear sticky flags and drop_count
//   rd_valid      out  at least one ID buffered
//   rd_data       out  ID_WIDTH  head ID, 0 when empty
//   fill_level    out  clog2(FIFO_DEPTH)+1  number of buffered IDs
//   interrupt     out  same as rd_valid
//   overflow_err  out  sticky: completed ID dropped on a full buffer
//   frame_err     out  sticky: capture aborted by timeout or retrigger
//   drop_count    out  8  saturating count of lost IDs
// -----------------------------------------------------------------------------
module trig_id_receiver
  import trig_id_receiver_pkg::*;
#(
  parameter int ID_WIDTH       = 16,
  parameter int FIFO_DEPTH     = 8,
  parameter int MSB_FIRST      = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        trig_sync,
  input  logic                        id_bit_sync,
  input  logic                        bit_strobe,
  input  logic                        rd_pop,
  input  logic                        err_clear,
  output logic                        rd_valid,
  output logic [ID_WIDTH-1:0]         rd_data,
  output logic [clog2(FIFO_DEPTH):0]  fill_level,
  output logic                        interrupt,
  output logic                        overflow_err,
  output logic                        frame_err,
  output logic [DROP_CNT_W-1:0]       drop_count
);

  localparam int CNT_W = clog2(ID_WIDTH) + 1;
  localparam int TMR_W = clog2(TIMEOUT_CYCLES) + 1;

  // ---------------------------------------------------------------------------
  // Capture datapath
  // ---------------------------------------------------------------------------
  fsm_state_t           state_q;
  logic                 trig_q;
  // Only ID_WIDTH-1 bits are ever held: the final bit goes straight from
  // id_bit_sync into the pushed word.
  logic [ID_WIDTH-2:0]  shift_q;
  logic [CNT_W-1:0]     bit_cnt_q;
  logic [TMR_W-1:0]     timer_q;

  logic                 trig_edge;
  logic                 last_bit;
  logic                 timeout_hit;
  logic                 in_capture;
  logic                 push;
  logic                 abort;
  logic [ID_WIDTH-1:0]  word_in;
  logic [ID_WIDTH-2:0]  shift_d;

  assign trig_edge   = trig_sync && !trig_q;
  assign in_capture  = (state_q == CAPTURE);
  assign last_bit    = (bit_cnt_q == CNT_W'(ID_WIDTH - 1));
  assign timeout_hit = (timer_q == TMR_W'(TIMEOUT_CYCLES - 1));

  // A trigger edge always wins over a strobe in the same cycle.
  assign push  = in_capture && !trig_edge && bit_strobe && last_bit;
  assign abort = in_capture && (trig_edge || (!bit_strobe && timeout_hit));

  // Bit order: the word that would result from shifting the current bit in.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign word_in = {shift_q, id_bit_sync};
      assign shift_d = word_in[ID_WIDTH-2:0];
    end else begin : g_lsb_first
      assign word_in = {id_bit_sync, shift_q};
      assign shift_d = word_in[ID_WIDTH-1:1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      trig_q    <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      timer_q   <= '0;
    end else begin
      trig_q <= trig_sync;
      case (state_q)
        IDLE: begin
          if (trig_edge) begin
            state_q   <= CAPTURE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            timer_q   <= '0;
          end
        end
        CAPTURE: begin
          if (trig_edge) begin
            // Retrigger: restart the capture from scratch.
            shift_q   <= '0;
            bit_cnt_q <= '0;
            timer_q   <= '0;
          end else if (bit_strobe) begin
            shift_q <= shift_d;
            timer_q <= '0;
            if (last_bit) begin
              state_q   <= IDLE;
              bit_cnt_q <= '0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else if (timeout_hit) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            timer_q   <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer
  // ---------------------------------------------------------------------------
  logic fifo_full;
  logic fifo_empty;

  id_fifo #(
    .WIDTH (ID_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (word_in),
    .pop_i   (rd_pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fill_level),
    .rdata_o (rd_data)
  );

  assign rd_valid  = !fifo_empty;
  assign interrupt = rd_valid;

  // ---------------------------------------------------------------------------
  // Error flags and drop counter
  // ---------------------------------------------------------------------------
  logic                  overflow_err_q;
  logic                  overflow_err_d;
  logic                  frame_err_q;
  logic                  frame_err_d;
  logic [DROP_CNT_W-1:0] drop_cnt_q;
  logic [DROP_CNT_W-1:0] drop_cnt_d;
  logic [DROP_CNT_W-1:0] drop_base;
  logic                  overflow_evt;
  logic                  drop_evt;

  // rd_pop while full is always a real pop, so it always makes room.
  assign overflow_evt = push && fifo_full && !rd_pop;
  assign drop_evt     = overflow_evt || abort;

  // err_clear clears first; an event in the same cycle is then applied on top.
  always_comb begin
    overflow_err_d = overflow_evt || (overflow_err_q && !err_clear);
    frame_err_d    = abort || (frame_err_q && !err_clear);
    drop_base      = err_clear ? '0 : drop_cnt_q;
    drop_cnt_d     = drop_base;
    if (drop_evt && (drop_base != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_d = drop_base + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_err_q <= 1'b0;
      frame_err_q    <= 1'b0;
      drop_cnt_q     <= '0;
    end else begin
      overflow_err_q <= overflow_err_d;
      frame_err_q    <= frame_err_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  assign overflow_err = overflow_err_q;
  assign frame_err    = frame_err_q;
  assign drop_count   = drop_cnt_q;

endmodule

// File: tb/tb_trig_id_receiver.sv
// -----------------------------------------------------------------------------
// tb_trig_id_receiver
//   Drives two receivers (MSB-first and LSB-first) from the same inputs and
//   compares them every cycle against a behavioural model built from queues:
//   the received bits of the current frame, and the buffered IDs.
// -----------------------------------------------------------------------------
module tb_trig_id_receiver;

  localparam int W     = 16;
  localparam int DEPTH = 8;
  localparam int TMO   = 64;

  logic clk = 1'b0;
  logic reset, trig_sync, id_bit_sync, bit_strobe, rd_pop, err_clear;

  logic         rd_valid, interrupt, overflow_err, frame_err;
  logic [W-1:0] rd_data;
  logic [3:0]   fill_level;
  logic [7:0]   drop_count;

  logic         rd_valid_l, interrupt_l, overflow_err_l, frame_err_l;
  logic [W-1:0] rd_data_l;
  logic [3:0]   fill_level_l;
  logic [7:0]   drop_count_l;

  always #5 clk = ~clk;

  trig_id_receiver #(
    .ID_WIDTH(W), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .trig_sync(trig_sync), .id_bit_sync(id_bit_sync),
    .bit_strobe(bit_strobe), .rd_pop(rd_pop), .err_clear(err_clear),
    .rd_valid(rd_valid), .rd_data(rd_data), .fill_level(fill_level),
    .interrupt(interrupt), .overflow_err(overflow_err), .frame_err(frame_err),
    .drop_count(drop_count)
  );

  trig_id_receiver #(
    .ID_WIDTH(W), .FIFO_DEPTH(DEPTH), .MSB_FIRST(0), .TIMEOUT_CYCLES(TMO)
  ) dut_lsb (
    .clk(clk), .reset(reset), .trig_sync(trig_sync), .id_bit_sync(id_bit_sync),
    .bit_strobe(bit_strobe), .rd_pop(rd_pop), .err_clear(err_clear),
    .rd_valid(rd_valid_l), .rd_data(rd_data_l), .fill_level(fill_level_l),
    .interrupt(interrupt_l), .overflow_err(overflow_err_l), .frame_err(frame_err_l),
    .drop_count(drop_count_l)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit           m_trig_prev;
  bit           m_cap;
  int           m_idle;
  bit           m_bits[$];
  logic [W-1:0] m_q_msb[$];
  logic [W-1:0] m_q_lsb[$];
  bit           m_ovf;
  bit           m_frm;
  int           m_drop;

  task automatic model_reset();
    m_trig_prev = 0; m_cap = 0; m_idle = 0;
    m_bits.delete(); m_q_msb.delete(); m_q_lsb.delete();
    m_ovf = 0; m_frm = 0; m_drop = 0;
  endtask

  task automatic model_step();
    bit edge_t, push_t, abort_t, pop_t, ovf_t;
    logic [W-1:0] wm, wl;
    if (reset) begin
      model_reset();
      return;
    end
    edge_t  = trig_sync && !m_trig_prev;
    m_trig_prev = trig_sync;
    push_t  = 0;
    abort_t = 0;
    wm = '0;
    wl = '0;
    pop_t = rd_pop && (m_q_msb.size() > 0);
    if (m_cap) begin
      if (edge_t) begin
        abort_t = 1; m_bits.delete(); m_idle = 0;
      end else if (bit_strobe) begin
        m_bits.push_back(id_bit_sync);
        m_idle = 0;
        if (m_bits.size() == W) begin
          // n-th received bit weighs 2**(W-1-n) MSB-first, 2**n LSB-first
          foreach (m_bits[i]) begin
            wm[W-1-i] = m_bits[i];
            wl[i]     = m_bits[i];
          end
          push_t = 1; m_cap = 0; m_bits.delete();
        end
      end else begin
        m_idle++;
        if (m_idle == TMO) begin
          abort_t = 1; m_cap = 0; m_bits.delete(); m_idle = 0;
        end
      end
    end else if (edge_t) begin
      m_cap = 1; m_bits.delete(); m_idle = 0;
    end
    ovf_t = push_t && (m_q_msb.size() == DEPTH) && !pop_t;
    if (pop_t) begin
      void'(m_q_msb.pop_front());
      void'(m_q_lsb.pop_front());
    end
    if (push_t && !ovf_t) begin
      m_q_msb.push_back(wm);
      m_q_lsb.push_back(wl);
    end
    if (push_t)
      $display("id 0x%04h / lsb-first 0x%04h %s, level %0d", wm, wl,
               ovf_t ? "dropped" : "queued", m_q_msb.size());
    if (err_clear) begin
      m_ovf = 0; m_frm = 0; m_drop = 0;
    end
    if (ovf_t) m_ovf = 1;
    if (abort_t) m_frm = 1;
    if ((ovf_t || abort_t) && m_drop < 255) m_drop++;
  endtask

  task automatic compare_all();
    int n;
    n = m_q_msb.size();
    check_eq("rd_valid",     rd_valid,     32'(n > 0));
    check_eq("interrupt",    interrupt,    32'(n > 0));
    check_eq("fill_level",   fill_level,   n);
    check_eq("rd_data",      rd_data,      (n > 0) ? m_q_msb[0] : '0);
    check_eq("overflow_err", overflow_err, 32'(m_ovf));
    check_eq("frame_err",    frame_err,    32'(m_frm));
    check_eq("drop_count",   drop_count,   m_drop);
    check_eq("lsb_rd_data",  rd_data_l,    (n > 0) ? m_q_lsb[0] : '0);
    check_eq("lsb_fill",     fill_level_l, n);
    check_eq("lsb_drop",     drop_count_l, m_drop);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic trigger();
    trig_sync = 1'b1; cycle();
    trig_sync = 1'b0; cycle();
  endtask

  // Sends the first n bits of val, starting at bit W-1, one idle cycle after each.
  task automatic send_bits(input logic [W-1:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      id_bit_sync = val[W-1-i];
      bit_strobe  = 1'b1; cycle();
      bit_strobe  = 1'b0;
      id_bit_sync = 1'($urandom_range(0, 1));
      cycle();
    end
  endtask

  task automatic send_id(input logic [W-1:0] val);
    trigger();
    send_bits(val, W);
  endtask

  task automatic pop_one();
    rd_pop = 1'b1; cycle();
    rd_pop = 1'b0;
  endtask

  task automatic clear_errors();
    err_clear = 1'b1; cycle();
    err_clear = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int strobe_pct, pop_pct;
    reset = 1'b1; trig_sync = 1'b0; id_bit_sync = 1'b0; bit_strobe = 1'b0;
    rd_pop = 1'b0; err_clear = 1'b0;
    model_reset();
    repeat (3) cycle();
    reset = 1'b0;
    check_eq("reset_rd_valid", rd_valid, 0);
    check_eq("reset_drop", drop_count, 0);
    $display("reset released");

    // Normal capture, both bit orders
    send_id(16'hA5C3);
    check_eq("normal_msb", rd_data, 16'hA5C3);
    check_eq("normal_lsb", rd_data_l, 16'hC3A5);
    check_eq("normal_irq", interrupt, 1);
    pop_one();
    check_eq("normal_pop_valid", rd_valid, 0);
    check_eq("normal_pop_data", rd_data, 0);
    $display("normal capture done");

    // Timeout: 5 strobes then 64 strobe-free cycles
    trigger();
    send_bits(16'hFFFF, 5);
    repeat (TMO - 1) cycle();
    check_eq("timeout_frame", frame_err, 1);
    check_eq("timeout_drop", drop_count, 1);
    check_eq("timeout_fill", fill_level, 0);
    send_id(16'h5A0F);
    check_eq("after_timeout_id", rd_data, 16'h5A0F);
    pop_one();
    $display("timeout done");

    // Retrigger
    clear_errors();
    check_eq("clear_frame", frame_err, 0);
    trigger();
    send_bits(16'hFFFF, 10);
    send_id(16'h1234);
    check_eq("retrig_frame", frame_err, 1);
    check_eq("retrig_drop", drop_count, 1);
    check_eq("retrig_fill", fill_level, 1);
    check_eq("retrig_id", rd_data, 16'h1234);
    pop_one();
    $display("retrigger done");

    // Overflow: 9 IDs, no pops
    clear_errors();
    for (int v = 1; v <= 9; v++) send_id(16'(v));
    check_eq("ovf_fill", fill_level, 8);
    check_eq("ovf_flag", overflow_err, 1);
    check_eq("ovf_drop", drop_count, 1);
    for (int v = 1; v <= 8; v++) begin
      check_eq("ovf_order", rd_data, v);
      pop_one();
    end
    $display("overflow done");

    // Overflow variant: 9th push coincides with a pop
    clear_errors();
    for (int v = 1; v <= 8; v++) send_id(16'(v));
    trigger();
    send_bits(16'd9, W - 1);
    id_bit_sync = 1'b1; bit_strobe = 1'b1; rd_pop = 1'b1;
    cycle();
    bit_strobe = 1'b0; rd_pop = 1'b0;
    check_eq("pushpop_ovf", overflow_err, 0);
    check_eq("pushpop_fill", fill_level, 8);
    for (int v = 2; v <= 9; v++) begin
      check_eq("pushpop_order", rd_data, v);
      pop_one();
    end
    $display("push-pop on full done");

    // err_clear with drop_count=3, then err_clear coinciding with an abort
    trigger(); trigger(); trigger(); trigger();
    check_eq("three_drops", drop_count, 3);
    clear_errors();
    check_eq("clr_drop", drop_count, 0);
    check_eq("clr_frame", frame_err, 0);
    trigger(); trigger(); trigger();
    trig_sync = 1'b1; err_clear = 1'b1; cycle();
    trig_sync = 1'b0; err_clear = 1'b0; cycle();
    check_eq("clr_vs_evt_frame", frame_err, 1);
    check_eq("clr_vs_evt_drop", drop_count, 1);
    $display("err_clear done");

    // Saturation
    repeat (300) trigger();
    check_eq("sat_drop", drop_count, 255);
    trigger();
    check_eq("sat_hold", drop_count, 255);
    $display("saturation done");

    // Reset mid-capture
    trigger();
    send_bits(16'hFFFF, 8);
    reset = 1'b1; cycle();
    reset = 1'b0; cycle();
    check_eq("midrst_drop", drop_count, 0);
    check_eq("midrst_frame", frame_err, 0);
    check_eq("midrst_valid", rd_valid, 0);
    $display("reset mid-capture done");

    // Random phase
    strobe_pct = 30; pop_pct = 10;
    for (int c = 0; c < 20000; c++) begin
      if (c % 2000 == 0) begin
        strobe_pct = int'($urandom_range(3, 70));
        pop_pct    = int'($urandom_range(0, 25));
        $display("random epoch %0d: strobe %0d%%, pop %0d%%", c / 2000, strobe_pct, pop_pct);
      end
      reset       = ($urandom_range(0, 1499) == 0);
      trig_sync   = trig_sync ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 69) == 0);
      bit_strobe  = (int'($urandom_range(0, 99)) < strobe_pct);
      id_bit_sync = 1'($urandom_range(0, 1));
      rd_pop      = (int'($urandom_range(0, 99)) < pop_pct);
      err_clear   = ($urandom_range(0, 79) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trig_id_receiver.md
Name: trig_id_receiver

Overview:
- Parametrised successor to the single-word trigger-ID capture logic in the FPGA top level.
- Captures serial trigger IDs of configurable width and bit order, framed by the synchronised trigger pulse and the bit strobe from the falling edge of the external clock.
- Buffers completed IDs in a FIFO for SPI readout and drives the MCU interrupt.
- Adds timeout, retrigger and overflow detection, all absent in the current design.

Parameters:
- ID_WIDTH, 16, bits per trigger ID (2..32).
- FIFO_DEPTH, 8, number of buffered IDs; power of two, 2..64.
- MSB_FIRST, 1, 1 = first serial bit lands in bit ID_WIDTH-1; 0 = first bit lands in bit 0.
- TIMEOUT_CYCLES, 64, maximum clk cycles allowed between trigger and first strobe, or between consecutive strobes.

Ports:
- clk  in  1  sampling clock (pll_clk domain).
- reset  in  1  synchronous reset, active-high.
- trig_sync  in  1  trigger input, already synchronised to clk; level signal.
- id_bit_sync  in  1  serial ID data, already synchronised to clk.
- bit_strobe  in  1  one-cycle pulse marking a valid id_bit_sync sample (falling edge of the external clock).
- rd_pop  in  1  consumes the head word when rd_valid=1; ignored when rd_valid=0.
- err_clear  in  1  clears the sticky error flags and drop_count.
- rd_valid  out  1  FIFO non-empty.
- rd_data  out  ID_WIDTH  head-of-FIFO ID; 0 when empty.
- fill_level  out  clog2(FIFO_DEPTH)+1  number of stored words.
- interrupt  out  1  equals rd_valid; active-high (inverted at the top level if required).
- overflow_err  out  1  sticky: a completed ID was dropped because the FIFO was full.
- frame_err  out  1  sticky: a capture was aborted by timeout or retrigger.
- drop_count  out  8  saturating count of IDs lost to overflow or abort.

Behaviour:
- Reset:
  - FSM enters IDLE; FIFO is emptied.
  - rd_valid=0, rd_data=0, fill_level=0, interrupt=0, overflow_err=0, frame_err=0, drop_count=0.
  - Reset takes priority over all other inputs.
  - Reset mid-capture discards the partial word with no error flagged.
- Trigger detection: a rising edge of trig_sync (registered previous value 0, current value 1) starts a capture. A level held high does not retrigger.
- FSM states:
  - IDLE: on trigger edge, go to CAPTURE; shift register=0, bit_cnt=0, timer=0.
  - CAPTURE:
    - On bit_strobe: shift in id_bit_sync according to MSB_FIRST, bit_cnt++, timer=0.
    - Without bit_strobe: timer++.
    - When bit_cnt reaches ID_WIDTH-1 and bit_strobe=1: push the assembled word (including the current bit) into the FIFO at that same edge, then go to IDLE.
    - If timer reaches TIMEOUT_CYCLES-1 without a strobe: abort, frame_err=1, drop_count++, go to IDLE.
    - New trigger edge during CAPTURE: abort the current word, frame_err=1, drop_count++, restart CAPTURE with counters cleared.
    - Trigger edge and bit_strobe on the same cycle: the trigger wins and the strobe is ignored.
- Latency: rd_valid and fill_level update on the edge after the final-bit strobe. rd_data is valid in that same cycle.
- FIFO:
  - Circular buffer with read/write pointers of clog2(FIFO_DEPTH)+1 bits; the extra bit distinguishes full from empty.
  - Pointer wrap is natural binary.
  - Pop when empty: ignored.
  - Push when full without pop: word dropped, overflow_err=1, drop_count++.
  - Push and pop on the same cycle when full: both succeed; fill_level unchanged; no error.
  - Push and pop on the same cycle when fill_level=1: new word becomes the head; rd_valid stays 1.
  - rd_data is driven from the read pointer. When empty it is forced to 0.
- drop_count saturates at 255.
- err_clear:
  - Clears overflow_err, frame_err and drop_count on the next edge.
  - An error event on the same cycle as err_clear wins: the flag stays set and drop_count becomes 1.

Decomposition:
- Shared package holds:
  - Typedef fsm_state_t with values IDLE and CAPTURE.
  - DROP_CNT_W = 8.
  - A clog2 helper function.
- One sub-module, id_fifo:
  - Parameterised on WIDTH and DEPTH.
  - Provides push, pop, full, empty, level and head data outputs.
  - Contains no error logic.
- The FSM, shifter, timer and error logic live in trig_id_receiver.

Test Plan:
- Normal capture: ID_WIDTH=16, MSB_FIRST=1, trigger then 16 strobes carrying 0xA5C3 -> rd_valid=1 one cycle after the last strobe, rd_data=0xA5C3, interrupt=1; after rd_pop, rd_valid=0 and rd_data=0.
- Bit order: MSB_FIRST=0, same bit stream -> rd_data=0xC3A5 bit-reversed (0xC3A5 ↔ serial order check), i.e. first bit received appears in bit 0.
- Overflow: 9 IDs 0x0001..0x0009 with no pops (DEPTH=8) -> fill_level=8, overflow_err=1, drop_count=1, and pops return 0x0001..0x0008 in order. Variant with the 9th push coinciding with a pop -> no error, and the final pop returns 0x0009.
- Timeout: trigger, 5 strobes, then 64 idle cycles -> frame_err=1, drop_count=1, FSM in IDLE, FIFO empty; the next complete ID is captured correctly.
- Retrigger: trigger, 10 strobes, new trigger, 16 strobes of 0x1234 -> frame_err=1, drop_count=1, and the FIFO holds only 0x1234.
- Reset and clear: reset asserted after 8 strobes -> all outputs 0 and no flags. err_clear asserted with frame_err=1 and drop_count=3 -> both 0 the next cycle. Hold drop_count at 255 and force another drop -> stays 255.
